// File: rtl/perceptron_pkg.sv
// perceptron_pkg
// Shared definitions for the perceptron sequencer: the sequencer state
// encoding, the configuration word indices (w0, w1, w2, n) and the
// sel_out codes that select a weight on the core's output mux.
package perceptron_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CRST,
        S_CFG,
        S_RDY,
        S_LX1,
        S_LX2,
        S_WAIT,
        S_CAPT,
        S_RDBK,
        S_ERR
    } seq_state_e;

    // Configuration word order as loaded into the core. The read-back
    // index reuses the first three values.
    localparam logic [1:0] CFG_W0 = 2'd0;
    localparam logic [1:0] CFG_W1 = 2'd1;
    localparam logic [1:0] CFG_W2 = 2'd2;
    localparam logic [1:0] CFG_N  = 2'd3;

    // Core output mux select codes.
    localparam logic [1:0] SEL_NONE = 2'd0;
    localparam logic [1:0] SEL_W0   = 2'd1;
    localparam logic [1:0] SEL_W1   = 2'd2;
    localparam logic [1:0] SEL_W2   = 2'd3;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// seq_watchdog
// Loadable down-counter guarding the wait for core done.
//   clk, reset   system clock, async active-high reset
//   load_i       reload the counter with WATCHDOG-1
//   en_i         count down by one (stops at zero)
//   expire_o     counter has reached its terminal count of zero
module seq_watchdog #(
    parameter int WATCHDOG = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CW = (WATCHDOG > 1) ? $clog2(WATCHDOG) : 1;
    // Loaded with WATCHDOG-1 so that expire_o is seen in the WATCHDOG-th
    // enabled cycle after the load.
    localparam logic [CW-1:0] LOAD_VAL = CW'(WATCHDOG - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/perceptron_sequencer.sv
// perceptron_sequencer
// Host-side controller for the three-weight perceptron core. Loads the
// configuration words (w0, w1, w2, n), streams classify/train samples into
// the core, reports one result per sample and optionally reads the
// updated weights back.
//   clk, reset                       system clock, async active-high reset
//   cfg_valid/cfg_ready/cfg_data     configuration word handshake
//   s_valid/s_ready, s_x1, s_x2,
//   s_label, s_train                 sample handshake and payload
//   r_valid, r_class, r_miss         result strobe and result
//   r_w0..r_w2                       last read-back weights
//   miss_count, busy, error          status
//   p_*                              perceptron core control and status
//
// state | meaning
// IDLE  | unconfigured, waiting for the first config word
// CRST  | core held in reset for one cycle, error cleared
// CFG   | loading w0 (latched), then w1, w2, n from the host
// RDY   | configured, accepting samples; x1 loaded on the handshake cycle
// LX1   | reserved; x1 load happens inside RDY
// LX2   | loading x2, watchdog armed
// WAIT  | core computing; update/correct held, watchdog counting
// CAPT  | result captured from the core
// RDBK  | weights read back through the core output mux
// ERR   | sync or watchdog failure, waiting for a new configuration
module perceptron_sequencer
    import perceptron_pkg::*;
#(
    parameter int WATCHDOG = 16,
    parameter int READBACK = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [5:0] cfg_data,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [5:0] s_x1,
    input  logic [5:0] s_x2,
    input  logic       s_label,
    input  logic       s_train,
    output logic       r_valid,
    output logic       r_class,
    output logic       r_miss,
    output logic [5:0] r_w0,
    output logic [5:0] r_w1,
    output logic [5:0] r_w2,
    output logic [7:0] miss_count,
    output logic       busy,
    output logic       error,
    output logic       p_reset_l,
    output logic       p_go,
    output logic       p_update,
    output logic       p_correct,
    output logic [5:0] p_in_val,
    output logic [1:0] p_sel_out,
    input  logic       p_done,
    input  logic       p_class,
    input  logic       p_sync,
    input  logic [5:0] p_out_val
);

    seq_state_e state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [5:0] w0_q, w0_d;
    logic [5:0] x2_q, x2_d;
    logic       label_q, label_d;
    logic       train_q, train_d;
    logic       r_valid_q, r_valid_d;
    logic       r_class_q, r_class_d;
    logic       r_miss_q, r_miss_d;
    logic [5:0] r_w0_q, r_w0_d;
    logic [5:0] r_w1_q, r_w1_d;
    logic [5:0] r_w2_q, r_w2_d;
    logic [7:0] miss_cnt_q, miss_cnt_d;
    logic       error_q, error_d;

    logic       wd_load;
    logic       wd_en;
    logic       wd_expire;
    logic       miss_now;

    seq_watchdog #(
        .WATCHDOG (WATCHDOG)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .load_i   (wd_load),
        .en_i     (wd_en),
        .expire_o (wd_expire)
    );

    assign miss_now = p_class ^ label_q;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        w0_d       = w0_q;
        x2_d       = x2_q;
        label_d    = label_q;
        train_d    = train_q;
        r_valid_d  = 1'b0;
        r_class_d  = r_class_q;
        r_miss_d   = r_miss_q;
        r_w0_d     = r_w0_q;
        r_w1_d     = r_w1_q;
        r_w2_d     = r_w2_q;
        miss_cnt_d = miss_cnt_q;
        error_d    = error_q;
        wd_load    = 1'b0;
        wd_en      = 1'b0;

        cfg_ready  = 1'b0;
        s_ready    = 1'b0;
        p_reset_l  = 1'b1;
        p_go       = 1'b0;
        p_update   = 1'b0;
        p_correct  = 1'b0;
        p_in_val   = 6'd0;
        p_sel_out  = SEL_NONE;

        case (state_q)
            S_IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    w0_d    = cfg_data;
                    state_d = S_CRST;
                end
            end

            S_CRST: begin
                p_reset_l = 1'b0;
                error_d   = 1'b0;
                idx_d     = CFG_W0;
                state_d   = S_CFG;
            end

            S_CFG: begin
                // w0 was taken in the handshake that started configuration;
                // the remaining words are passed straight from the host.
                if (idx_q == CFG_W0) begin
                    p_go     = 1'b1;
                    p_in_val = w0_q;
                end else begin
                    cfg_ready = 1'b1;
                    if (cfg_valid) begin
                        p_go     = 1'b1;
                        p_in_val = cfg_data;
                    end
                end
                if (p_go) begin
                    if (!p_sync) begin
                        error_d = 1'b1;
                        state_d = S_ERR;
                    end else if (idx_q == CFG_N) begin
                        miss_cnt_d = 8'd0;
                        state_d    = S_RDY;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end

            S_RDY: begin
                cfg_ready = 1'b1;
                s_ready   = 1'b1;
                // A configuration request takes priority; a sample offered
                // in the same cycle is not forwarded to the core.
                if (cfg_valid) begin
                    w0_d    = cfg_data;
                    state_d = S_CRST;
                end else if (s_valid) begin
                    p_go     = 1'b1;
                    p_in_val = s_x1;
                    x2_d     = s_x2;
                    label_d  = s_label;
                    train_d  = s_train;
                    if (!p_sync) begin
                        error_d = 1'b1;
                        state_d = S_ERR;
                    end else begin
                        state_d = S_LX2;
                    end
                end
            end

            S_LX2: begin
                p_go     = 1'b1;
                p_in_val = x2_q;
                wd_load  = 1'b1;
                state_d  = S_WAIT;
            end

            S_WAIT: begin
                p_update  = train_q;
                p_correct = label_q;
                wd_en     = 1'b1;
                if (p_done) begin
                    state_d = S_CAPT;
                end else if (wd_expire) begin
                    error_d = 1'b1;
                    state_d = S_ERR;
                end
            end

            S_CAPT: begin
                r_class_d = p_class;
                r_miss_d  = miss_now;
                r_valid_d = 1'b1;
                if (miss_now) begin
                    miss_cnt_d = sat_inc8(miss_cnt_q);
                end
                if (train_q && (READBACK != 0)) begin
                    idx_d   = CFG_W0;
                    state_d = S_RDBK;
                end else begin
                    state_d = S_RDY;
                end
            end

            S_RDBK: begin
                case (idx_q)
                    CFG_W0: begin
                        p_sel_out = SEL_W0;
                        r_w0_d    = p_out_val;
                    end
                    CFG_W1: begin
                        p_sel_out = SEL_W1;
                        r_w1_d    = p_out_val;
                    end
                    default: begin
                        p_sel_out = SEL_W2;
                        r_w2_d    = p_out_val;
                    end
                endcase
                if (idx_q == CFG_W2) begin
                    state_d = S_RDY;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end

            S_ERR: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    w0_d    = cfg_data;
                    state_d = S_CRST;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            idx_q      <= CFG_W0;
            w0_q       <= 6'd0;
            x2_q       <= 6'd0;
            label_q    <= 1'b0;
            train_q    <= 1'b0;
            r_valid_q  <= 1'b0;
            r_class_q  <= 1'b0;
            r_miss_q   <= 1'b0;
            r_w0_q     <= 6'd0;
            r_w1_q     <= 6'd0;
            r_w2_q     <= 6'd0;
            miss_cnt_q <= 8'd0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            w0_q       <= w0_d;
            x2_q       <= x2_d;
            label_q    <= label_d;
            train_q    <= train_d;
            r_valid_q  <= r_valid_d;
            r_class_q  <= r_class_d;
            r_miss_q   <= r_miss_d;
            r_w0_q     <= r_w0_d;
            r_w1_q     <= r_w1_d;
            r_w2_q     <= r_w2_d;
            miss_cnt_q <= miss_cnt_d;
            error_q    <= error_d;
        end
    end

    assign r_valid    = r_valid_q;
    assign r_class    = r_class_q;
    assign r_miss     = r_miss_q;
    assign r_w0       = r_w0_q;
    assign r_w1       = r_w1_q;
    assign r_w2       = r_w2_q;
    assign miss_count = miss_cnt_q;
    assign error      = error_q;
    assign busy       = !((state_q == S_IDLE) || (state_q == S_RDY));

endmodule

// File: tb/tb_perceptron_sequencer.sv
// tb_perceptron_sequencer
// Directed bench for perceptron_sequencer with a small behavioural model of
// the perceptron core (weights, Q3.3 dot product, perceptron update rule).
module tb_perceptron_sequencer;
    import perceptron_pkg::*;

    localparam int TRAIN_DLY = 3;

    logic       clk;
    logic       reset;
    logic       cfg_valid, cfg_ready;
    logic [5:0] cfg_data;
    logic       s_valid, s_ready;
    logic [5:0] s_x1, s_x2;
    logic       s_label, s_train;
    logic       r_valid, r_class, r_miss;
    logic [5:0] r_w0, r_w1, r_w2;
    logic [7:0] miss_count;
    logic       busy, error;
    logic       p_reset_l, p_go, p_update, p_correct;
    logic [5:0] p_in_val;
    logic [1:0] p_sel_out;
    logic       p_done, p_class, p_sync;
    logic [5:0] p_out_val;

    int checks = 0;
    int errors = 0;

    perceptron_sequencer #(
        .WATCHDOG (16),
        .READBACK (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_data   (cfg_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_x1       (s_x1),
        .s_x2       (s_x2),
        .s_label    (s_label),
        .s_train    (s_train),
        .r_valid    (r_valid),
        .r_class    (r_class),
        .r_miss     (r_miss),
        .r_w0       (r_w0),
        .r_w1       (r_w1),
        .r_w2       (r_w2),
        .miss_count (miss_count),
        .busy       (busy),
        .error      (error),
        .p_reset_l  (p_reset_l),
        .p_go       (p_go),
        .p_update   (p_update),
        .p_correct  (p_correct),
        .p_in_val   (p_in_val),
        .p_sel_out  (p_sel_out),
        .p_done     (p_done),
        .p_class    (p_class),
        .p_sync     (p_sync),
        .p_out_val  (p_out_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- core model ----------------
    logic signed [5:0] cw [4] = '{default: 6'sd0};
    logic signed [5:0] mx1 = 6'sd0;
    logic signed [5:0] mx2 = 6'sd0;
    int   ld = 0;
    int   tmr = 0;
    logic pend = 1'b0;
    logic cls_r = 1'b0;
    logic withhold = 1'b0;
    logic drop_sync = 1'b0;
    logic m_cls;

    function automatic int wsum(input int w0, input int w1, input int w2,
                                input int x1, input int x2);
        return w0 * 8 + w1 * x1 + w2 * x2;
    endfunction

    function automatic logic [5:0] upd(input int w, input int x, input int n,
                                       input logic corr);
        int d;
        d = (n * x) >>> 3;
        return 6'(corr ? (w + d) : (w - d));
    endfunction

    assign m_cls     = wsum(int'(cw[0]), int'(cw[1]), int'(cw[2]),
                            int'(mx1), int'(mx2)) > 0;
    assign p_sync    = p_go && !(drop_sync && (ld == 1));
    assign p_done    = pend && !withhold && (!p_update || (tmr == TRAIN_DLY));
    assign p_class   = cls_r;
    assign p_out_val = (p_sel_out == SEL_W0) ? cw[0] :
                       (p_sel_out == SEL_W1) ? cw[1] :
                       (p_sel_out == SEL_W2) ? cw[2] : 6'd0;

    always @(posedge clk) begin
        if (!p_reset_l) begin
            ld    <= 0;
            pend  <= 1'b0;
            tmr   <= 0;
            cls_r <= 1'b0;
            for (int i = 0; i < 4; i++) cw[i] <= 6'sd0;
        end else begin
            if (p_go) begin
                if (ld < 4) cw[ld] <= p_in_val;
                else if (ld == 4) mx1 <= p_in_val;
                else begin
                    mx2  <= p_in_val;
                    pend <= 1'b1;
                    tmr  <= 0;
                end
                ld <= (ld < 5) ? ld + 1 : 4;
            end
            if (pend) begin
                if (p_done) begin
                    pend  <= 1'b0;
                    cls_r <= m_cls;
                    if (p_update && (m_cls != p_correct)) begin
                        cw[0] <= upd(int'(cw[0]), 8,         int'(cw[3]), p_correct);
                        cw[1] <= upd(int'(cw[1]), int'(mx1), int'(cw[3]), p_correct);
                        cw[2] <= upd(int'(cw[2]), int'(mx2), int'(cw[3]), p_correct);
                    end
                end else begin
                    tmr <= tmr + 1;
                end
            end
        end
    end

    // ---------------- event counters ----------------
    int go_cnt = 0, sync_cnt = 0, rstl_cnt = 0, rv_cnt = 0;
    always @(negedge clk) begin
        if (!reset) begin
            if (p_go) go_cnt <= go_cnt + 1;
            if (p_go && p_sync) sync_cnt <= sync_cnt + 1;
            if (!p_reset_l) rstl_cnt <= rstl_cnt + 1;
            if (r_valid) rv_cnt <= rv_cnt + 1;
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_word(input logic [5:0] w);
        int n;
        cfg_valid = 1'b1;
        cfg_data  = w;
        n = 0;
        while (!cfg_ready && n < 20) begin
            step();
            n++;
        end
        chk("cfg_handshake", cfg_ready, 1);
        step();
        cfg_valid = 1'b0;
        cfg_data  = 6'd0;
    endtask

    task automatic configure(input logic [5:0] a, input logic [5:0] b,
                             input logic [5:0] c, input logic [5:0] d);
        cfg_word(a);
        cfg_word(b);
        cfg_word(c);
        cfg_word(d);
    endtask

    task automatic s_hs(input logic [5:0] x1, input logic [5:0] x2,
                        input logic label, input logic train);
        int n;
        s_valid = 1'b1;
        s_x1 = x1;
        s_x2 = x2;
        s_label = label;
        s_train = train;
        n = 0;
        while (!s_ready && n < 30) begin
            step();
            n++;
        end
        chk("s_handshake", s_ready, 1);
        step();
        s_valid = 1'b0;
        s_train = 1'b0;
    endtask

    // Returns the number of cycles from the handshake cycle to r_valid.
    task automatic wait_rv(output int lat);
        lat = 1;
        while (!r_valid && lat < 60) begin
            step();
            lat++;
        end
        chk("r_valid_seen", r_valid, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    int lat, n, acc, g0, s0, r0, rv0;

    initial begin
        reset = 1'b1;
        cfg_valid = 1'b0;
        cfg_data = 6'd0;
        s_valid = 1'b0;
        s_x1 = 6'd0;
        s_x2 = 6'd0;
        s_label = 1'b0;
        s_train = 1'b0;
        repeat (2) step();

        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_error", error, 0);
        chk("rst_p_reset_l", p_reset_l, 1);
        chk("rst_p_go", p_go, 0);
        chk("rst_r_valid", r_valid, 0);
        chk("rst_miss_count", miss_count, 0);
        chk("rst_p_sel_out", p_sel_out, 0);

        reset = 1'b0;
        step();

        // Configuration w=1.0, n=0.5
        r0 = rstl_cnt; g0 = go_cnt; s0 = sync_cnt;
        configure(6'd8, 6'd8, 6'd8, 6'd4);
        chk("cfg1_s_ready", s_ready, 1);
        chk("cfg1_busy", busy, 0);
        chk("cfg1_rstl_cycles", rstl_cnt - r0, 1);
        chk("cfg1_go_cycles", go_cnt - g0, 4);
        chk("cfg1_sync_cycles", sync_cnt - s0, 4);

        // Classify: 8+8+8 > 0 -> class 1
        s_hs(6'd8, 6'd8, 1'b1, 1'b0);
        chk("cls1_busy", busy, 1);
        chk("cls1_s_ready", s_ready, 0);
        wait_rv(lat);
        chk("cls1_latency", lat, 4);
        chk("cls1_class", r_class, 1);
        chk("cls1_miss", r_miss, 0);
        chk("cls1_miss_count", miss_count, 0);
        step();
        chk("cls1_r_valid_one_cycle", r_valid, 0);

        s_hs(6'd8, 6'd8, 1'b0, 1'b0);
        wait_rv(lat);
        chk("cls2_class", r_class, 1);
        chk("cls2_miss", r_miss, 1);
        chk("cls2_miss_count", miss_count, 1);

        // x = -1.0, -1.0: 8 - 8 - 8 < 0 -> class 0
        s_hs(6'h38, 6'h38, 1'b0, 1'b0);
        wait_rv(lat);
        chk("cls3_latency", lat, 4);
        chk("cls3_class", r_class, 0);
        chk("cls3_miss", r_miss, 0);
        chk("cls3_miss_count", miss_count, 1);

        // Reconfigure from RDY to all-zero weights, stalling before w1
        cfg_word(6'd0);
        step();
        step();
        g0 = go_cnt; s0 = sync_cnt;
        for (int i = 0; i < 3; i++) begin
            chk("stall_p_go", p_go, 0);
            chk("stall_cfg_ready", cfg_ready, 1);
            step();
        end
        chk("stall_go_cycles", go_cnt - g0, 0);
        cfg_word(6'd0);
        cfg_word(6'd0);
        cfg_word(6'd4);
        chk("cfg2_go_cycles", go_cnt - g0, 3);
        chk("cfg2_sync_cycles", sync_cnt - s0, 3);
        chk("cfg2_miss_count_cleared", miss_count, 0);
        chk("cfg2_s_ready", s_ready, 1);

        // Train: zero weights, x1=1.0, x2=0, label 1 -> miss, w0=w1=0.5
        s_hs(6'd8, 6'd0, 1'b1, 1'b1);
        wait_rv(lat);
        chk("trn_latency", lat, 4 + TRAIN_DLY);
        chk("trn_class", r_class, 0);
        chk("trn_miss", r_miss, 1);
        chk("trn_miss_count", miss_count, 1);
        chk("trn_s_ready_in_rdbk", s_ready, 0);
        n = 0;
        while (!s_ready && n < 10) begin
            step();
            n++;
        end
        chk("trn_rdbk_cycles", n, 3);
        chk("trn_r_w0", r_w0, 4);
        chk("trn_r_w1", r_w1, 4);
        chk("trn_r_w2", r_w2, 0);

        // Watchdog: core never reports done
        withhold = 1'b1;
        rv0 = rv_cnt;
        s_hs(6'd8, 6'd8, 1'b1, 1'b0);
        n = 1;
        while (!error && n < 40) begin
            step();
            n++;
        end
        chk("wd_cycles_to_error", n, 18);
        chk("wd_error", error, 1);
        chk("wd_busy", busy, 1);
        chk("wd_s_ready", s_ready, 0);
        chk("wd_cfg_ready", cfg_ready, 1);
        chk("wd_no_r_valid", rv_cnt - rv0, 0);
        withhold = 1'b0;
        r0 = rstl_cnt;
        cfg_word(6'd8);
        chk("wd_crst_p_reset_l", p_reset_l, 0);
        step();
        chk("wd_cfg_p_reset_l", p_reset_l, 1);
        chk("wd_error_cleared", error, 0);
        cfg_word(6'd8);
        cfg_word(6'd8);
        cfg_word(6'd4);
        chk("wd_rstl_cycles", rstl_cnt - r0, 1);
        chk("wd_recover_s_ready", s_ready, 1);

        // Missing sync during the w1 load
        drop_sync = 1'b1;
        cfg_word(6'd8);
        cfg_word(6'd8);
        chk("sync_error", error, 1);
        chk("sync_busy", busy, 1);
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            acc += int'(s_ready);
            step();
        end
        chk("sync_no_s_ready", acc, 0);
        drop_sync = 1'b0;
        configure(6'd8, 6'd8, 6'd8, 6'd4);
        chk("sync_recover_error", error, 0);

        // Reset while the core is computing a train sample
        withhold = 1'b1;
        s_hs(6'd8, 6'd8, 1'b1, 1'b1);
        step();
        step();
        chk("mid_pre_p_update", p_update, 1);
        chk("mid_pre_busy", busy, 1);
        chk("mid_pre_r_w0", r_w0, 4);
        rv0 = rv_cnt;
        reset = 1'b1;
        #1;
        chk("mid_busy", busy, 0);
        chk("mid_cfg_ready", cfg_ready, 1);
        chk("mid_s_ready", s_ready, 0);
        chk("mid_r_valid", r_valid, 0);
        chk("mid_p_update", p_update, 0);
        chk("mid_p_correct", p_correct, 0);
        chk("mid_p_go", p_go, 0);
        chk("mid_p_reset_l", p_reset_l, 1);
        chk("mid_r_w0", r_w0, 0);
        chk("mid_miss_count", miss_count, 0);
        chk("mid_error", error, 0);
        repeat (2) step();
        reset = 1'b0;
        withhold = 1'b0;
        repeat (5) step();
        chk("mid_no_r_valid", rv_cnt - rv0, 0);

        // Saturation: zero weights, n=0 so every label-1 sample misses
        configure(6'd0, 6'd0, 6'd0, 6'd0);
        for (int i = 0; i < 300; i++) begin
            s_hs(6'd0, 6'd0, 1'b1, 1'b0);
            wait_rv(lat);
            if (i == 253) chk("sat_254", miss_count, 254);
            if (i == 254) chk("sat_255", miss_count, 255);
        end
        chk("sat_final", miss_count, 255);
        chk("sat_last_miss", r_miss, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
